half_normalize: RTL and testbench

- Post-add normalization and rounding stage for the half-precision adder datapath.
- Consumes the raw, unnormalized adder result: sign, exponent, 12-bit mantissa with carry and hidden bit, plus guard/round/sticky.
- Produces a packed IEEE-754 binary16 word.
- Multi-cycle FSM: one shift per cycle, then round-to-nearest-even, with overflow-to-infinity and flush-to-zero underflow.

---
 rtl/half_normalize.sv | 123 ++++++++++++
 tb/tb_half_normalize.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/half_normalize.sv
// half_normalize: post-add normalize/round stage producing a packed binary16 result.
// Ports:
//   clk, nrst        rising-edge clock, asynchronous active-low reset
//   enable           start request, sampled only while idle
//   in_sign/in_expo  sign and biased exponent of the raw sum
//   in_mant          {carry, hidden, fraction[9:0]} of the raw sum
//   in_guard/in_round/in_sticky  extra precision bits below the fraction
//   out              packed {sign, expo, frac}, held until the next result
//   done             one-cycle pulse when out is updated
//   busy             high while an operation is in flight
module half_normalize #(
  parameter int EXP_W  = 5,
  parameter int FRAC_W = 10
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic                    enable,
  input  logic                    in_sign,
  input  logic [EXP_W-1:0]        in_expo,
  input  logic [FRAC_W+1:0]       in_mant,
  input  logic                    in_guard,
  input  logic                    in_round,
  input  logic                    in_sticky,
  output logic [EXP_W+FRAC_W:0]   out,
  output logic                    done,
  output logic                    busy
);
  typedef enum logic [2:0] {IDLE, SHIFT_R, SHIFT_L, ROUND, DONE} state_t;
  // one spare exponent bit so the all-ones and <=1 checks never wrap
  localparam logic [EXP_W:0] E_MAX = {1'b0, {EXP_W{1'b1}}};
  localparam logic [EXP_W:0] E_ONE = {{EXP_W{1'b0}}, 1'b1};
  state_t state, state_nx;
  logic s, s_nx, g, g_nx, r, r_nx, st, st_nx, inc;
  logic [EXP_W:0] e, e_nx, e_inc;
  logic [FRAC_W+1:0] m, m_nx, sum;
  logic [EXP_W+FRAC_W:0] out_nx, inf_word;
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign e_inc = e + E_ONE;
  assign inf_word = {s, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
  // round-to-nearest-even on the hidden bit plus fraction; sum[FRAC_W+1] is the rounding carry
  assign inc = g & (r | st | m[0]);
  assign sum = {1'b0, m[FRAC_W:0]} + {{(FRAC_W+1){1'b0}}, inc};
  always_comb begin
    state_nx = state;
    s_nx = s;
    e_nx = e;
    m_nx = m;
    g_nx = g;
    r_nx = r;
    st_nx = st;
    out_nx = out;
    case (state)
      IDLE: if (enable) begin
        s_nx = in_sign;
        e_nx = {1'b0, in_expo};
        m_nx = in_mant;
        g_nx = in_guard;
        r_nx = in_round;
        st_nx = in_sticky;
        if (in_expo == {EXP_W{1'b1}}) begin
          out_nx = {in_sign, {EXP_W{1'b1}}, in_mant[FRAC_W-1:0]};
          state_nx = DONE;
        end else if (in_mant == '0 && !(in_guard | in_round | in_sticky)) begin
          out_nx = '0;
          state_nx = DONE;
        end else begin
          state_nx = in_mant[FRAC_W+1] ? SHIFT_R : in_mant[FRAC_W] ? ROUND : SHIFT_L;
        end
      end
      SHIFT_R: begin
        st_nx = st | r;
        r_nx = g;
        g_nx = m[0];
        m_nx = m >> 1;
        e_nx = e_inc;
        out_nx = (e_inc == E_MAX) ? inf_word : out;
        state_nx = (e_inc == E_MAX) ? DONE : ROUND;
      end
      SHIFT_L: if (e <= E_ONE) begin
        // flush to zero instead of producing a subnormal
        out_nx = {s, {(EXP_W+FRAC_W){1'b0}}};
        state_nx = DONE;
      end else begin
        m_nx = {m[FRAC_W:0], g};
        g_nx = r;
        r_nx = 1'b0;
        e_nx = e - E_ONE;
        state_nx = m[FRAC_W-1] ? ROUND : SHIFT_L;
      end
      ROUND: begin
        m_nx = sum;
        e_nx = sum[FRAC_W+1] ? e_inc : e;
        out_nx = !sum[FRAC_W+1] ? {s, e[EXP_W-1:0], sum[FRAC_W-1:0]} :
                 (e_inc == E_MAX) ? inf_word : {s, e_inc[EXP_W-1:0], {FRAC_W{1'b0}}};
        state_nx = DONE;
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= IDLE;
      s <= 1'b0;
      e <= '0;
      m <= '0;
      g <= 1'b0;
      r <= 1'b0;
      st <= 1'b0;
      out <= '0;
    end else begin
      state <= state_nx;
      s <= s_nx;
      e <= e_nx;
      m <= m_nx;
      g <= g_nx;
      r <= r_nx;
      st <= st_nx;
      out <= out_nx;
    end
  end
endmodule

// File: tb/tb_half_normalize.sv
// tb_half_normalize: directed self-checking bench for half_normalize.
module tb_half_normalize;
  logic clk = 1'b0;
  logic nrst = 1'b0;
  logic enable = 1'b0;
  logic in_sign = 1'b0;
  logic [4:0] in_expo = '0;
  logic [11:0] in_mant = '0;
  logic in_guard = 1'b0, in_round = 1'b0, in_sticky = 1'b0;
  logic [15:0] out;
  logic done, busy;
  int checks = 0;
  int errors = 0;

  half_normalize dut (
    .clk(clk), .nrst(nrst), .enable(enable), .in_sign(in_sign), .in_expo(in_expo),
    .in_mant(in_mant), .in_guard(in_guard), .in_round(in_round), .in_sticky(in_sticky),
    .out(out), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic sg, input logic [4:0] ex, input logic [11:0] mt, input logic [2:0] grs);
    in_sign = sg;
    in_expo = ex;
    in_mant = mt;
    {in_guard, in_round, in_sticky} = grs;
  endtask

  // launches one operation; lat counts cycles from the sampling edge to the done cycle (99 = timeout)
  task automatic run(input logic sg, input logic [4:0] ex, input logic [11:0] mt, input logic [2:0] grs,
                     output int lat, output logic [15:0] res, output logic bsy, output logic after);
    @(negedge clk);
    drive(sg, ex, mt, grs);
    enable = 1'b1;
    @(posedge clk);
    #1;
    enable = 1'b0;
    drive(~sg, ~ex, ~mt, ~grs);
    bsy = busy;
    lat = 1;
    while (!done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!done) lat = 99;
    res = out;
    @(posedge clk);
    #1;
    after = done;
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if (out !== 16'h0000) begin errors++; $display("FAIL reset_out got %h want 0000", out); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    @(negedge clk);
    nrst = 1'b1;
  endtask

  task automatic test_normalized;
    int lat; logic [15:0] res; logic bsy, after;
    run(1'b0, 5'd15, 12'h400, 3'b000, lat, res, bsy, after);
    checks++;
    if (bsy !== 1'b1) begin errors++; $display("FAIL norm_busy got %b want 1", bsy); end
    checks++;
    if (res !== 16'h3C00 || lat != 2) begin errors++; $display("FAIL norm got %h lat %0d want 3c00 lat 2", res, lat); end
    checks++;
    if (after !== 1'b0) begin errors++; $display("FAIL norm_done_width got %b want 0", after); end
  endtask

  task automatic test_carry;
    int lat; logic [15:0] res; logic bsy, after;
    run(1'b0, 5'd15, 12'hC00, 3'b000, lat, res, bsy, after);
    checks++;
    if (res !== 16'h4200 || lat != 3) begin errors++; $display("FAIL carry_c00 got %h lat %0d want 4200 lat 3", res, lat); end
    run(1'b0, 5'd15, 12'hFFE, 3'b000, lat, res, bsy, after);
    checks++;
    if (res !== 16'h43FF || lat != 3) begin errors++; $display("FAIL carry_ffe got %h lat %0d want 43ff lat 3", res, lat); end
  endtask

  task automatic test_cancel;
    int lat; logic [15:0] res; logic bsy, after;
    run(1'b0, 5'd15, 12'h001, 3'b000, lat, res, bsy, after);
    checks++;
    if (res !== 16'h1400 || lat != 12) begin errors++; $display("FAIL cancel_001 got %h lat %0d want 1400 lat 12", res, lat); end
    run(1'b0, 5'd15, 12'h000, 3'b000, lat, res, bsy, after);
    checks++;
    if (res !== 16'h0000 || lat != 1) begin errors++; $display("FAIL cancel_zero got %h lat %0d want 0000 lat 1", res, lat); end
    run(1'b0, 5'd15, 12'h200, 3'b000, lat, res, bsy, after);
    checks++;
    if (res !== 16'h3800 || lat != 3) begin errors++; $display("FAIL cancel_one_shift got %h lat %0d want 3800 lat 3", res, lat); end
  endtask

  task automatic test_round;
    int lat; logic [15:0] res; logic bsy, after;
    run(1'b0, 5'd15, 12'h401, 3'b100, lat, res, bsy, after);
    checks++;
    if (res !== 16'h3C02) begin errors++; $display("FAIL round_tie_odd got %h want 3c02", res); end
    run(1'b0, 5'd15, 12'h400, 3'b100, lat, res, bsy, after);
    checks++;
    if (res !== 16'h3C00) begin errors++; $display("FAIL round_tie_even got %h want 3c00", res); end
    run(1'b0, 5'd15, 12'h400, 3'b101, lat, res, bsy, after);
    checks++;
    if (res !== 16'h3C01) begin errors++; $display("FAIL round_sticky got %h want 3c01", res); end
    run(1'b0, 5'd15, 12'h7FF, 3'b110, lat, res, bsy, after);
    checks++;
    if (res !== 16'h4000 || lat != 2) begin errors++; $display("FAIL round_carry got %h lat %0d want 4000 lat 2", res, lat); end
    run(1'b0, 5'd15, 12'hC03, 3'b000, lat, res, bsy, after);
    checks++;
    if (res !== 16'h4202) begin errors++; $display("FAIL round_after_shr got %h want 4202", res); end
  endtask

  task automatic test_overflow;
    int lat; logic [15:0] res; logic bsy, after;
    run(1'b0, 5'd30, 12'hFFE, 3'b000, lat, res, bsy, after);
    checks++;
    if (res !== 16'h7C00 || lat != 2) begin errors++; $display("FAIL ovf_shr got %h lat %0d want 7c00 lat 2", res, lat); end
    run(1'b0, 5'd30, 12'h7FF, 3'b110, lat, res, bsy, after);
    checks++;
    if (res !== 16'h7C00) begin errors++; $display("FAIL ovf_round got %h want 7c00", res); end
    run(1'b1, 5'd2, 12'h001, 3'b000, lat, res, bsy, after);
    checks++;
    if (res !== 16'h8000 || lat != 3) begin errors++; $display("FAIL underflow got %h lat %0d want 8000 lat 3", res, lat); end
    run(1'b0, 5'd31, 12'h7FF, 3'b000, lat, res, bsy, after);
    checks++;
    if (res !== 16'h7FFF || lat != 1) begin errors++; $display("FAIL nan_pass got %h lat %0d want 7fff lat 1", res, lat); end
  endtask

  task automatic test_busy_ignore;
    int pulses = 0;
    @(negedge clk);
    drive(1'b0, 5'd15, 12'h001, 3'b000);
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    drive(1'b0, 5'd31, 12'h3FF, 3'b000);
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (done) pulses++;
    end
    checks++;
    if (pulses != 1 || out !== 16'h1400) begin errors++; $display("FAIL busy_ignore pulses %0d out %h want 1 pulse 1400", pulses, out); end
  endtask

  task automatic test_reset_mid;
    int pulses = 0;
    @(negedge clk);
    drive(1'b0, 5'd15, 12'h001, 3'b000);
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before got %b want 1", busy); end
    nrst = 1'b0;
    #1;
    checks++;
    if (out !== 16'h0000 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL mid_reset out %h busy %b done %b want 0000 0 0", out, busy, done);
    end
    @(negedge clk);
    nrst = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (done) pulses++;
    end
    checks++;
    if (pulses != 0 || out !== 16'h0000) begin errors++; $display("FAIL mid_no_done pulses %0d out %h want 0 0000", pulses, out); end
  endtask

  task automatic test_back_to_back;
    int c = 0, c1 = 0, c2 = 0;
    @(negedge clk);
    drive(1'b0, 5'd15, 12'h400, 3'b000);
    enable = 1'b1;
    while (c2 == 0 && c < 30) begin
      @(posedge clk);
      #1;
      c++;
      if (done && c1 == 0) begin
        c1 = c;
        checks++;
        if (out !== 16'h3C00) begin errors++; $display("FAIL b2b_first got %h want 3c00", out); end
        drive(1'b0, 5'd31, 12'h7FF, 3'b000);
      end else if (done) begin
        c2 = c;
        enable = 1'b0;
      end
    end
    enable = 1'b0;
    checks++;
    if (c1 != 2 || c2 - c1 != 2 || out !== 16'h7FFF) begin
      errors++; $display("FAIL b2b first %0d second %0d out %h want 2 4 7fff", c1, c2, out);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_normalized();
    test_carry();
    test_cancel();
    test_round();
    test_overflow();
    test_busy_ignore();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
